// File: rtl/axi_lite_sram_ctrl.sv
// AXI-lite slave in front of an on-chip word-array SRAM.
// One holding buffer per request channel, fixed or round-robin read/write arbitration, programmable access latency.
module axi_lite_sram_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    parameter int ARB_RR  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic                busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic                last_grant_reg;   // 1 = last grant went to the write side
    logic                ar_full_reg, aw_full_reg, w_full_reg;
    logic                arready_reg, awready_reg, wready_reg;
    logic [IDX_W-1:0]    ar_idx_reg, aw_idx_reg;
    logic                ar_oor_reg, aw_oor_reg;
    logic [DATA_W-1:0]   w_data_reg;
    logic [STRB_W-1:0]   w_strb_reg;
    logic                rvalid_reg, bvalid_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [1:0]          rresp_reg, bresp_reg;
    logic [DATA_W-1:0]   mem_rd_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic ar_cap, aw_cap, w_cap;
    logic rd_done, wr_done;
    logic ar_full_next, aw_full_next, w_full_next;
    logic rd_pend, wr_pend, grant_rd, grant_wr;
    logic commit_wr;

    always_comb begin
        ar_cap       = arvalid && arready_reg;
        aw_cap       = awvalid && awready_reg;
        w_cap        = wvalid && wready_reg;
        rd_done      = (state_reg == RD_RESP) && rready;
        wr_done      = (state_reg == WR_RESP) && bready;
        ar_full_next = (ar_full_reg && !rd_done) || ar_cap;
        aw_full_next = (aw_full_reg && !wr_done) || aw_cap;
        w_full_next  = (w_full_reg && !wr_done) || w_cap;
        rd_pend      = ar_full_reg;
        wr_pend      = aw_full_reg && w_full_reg;
        // With both pending, round-robin serves the side that did not win last time.
        grant_rd     = rd_pend && (!wr_pend || (ARB_RR == 0) || last_grant_reg);
        grant_wr     = wr_pend && !grant_rd;
        commit_wr    = (state_reg == WR_WAIT) && (cnt_reg == 4'd0) && !aw_oor_reg && !rst;
    end

    // SRAM: byte-masked write, registered read of the pending read index.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_reg[b]) begin
                    mem[aw_idx_reg][b*8 +: 8] <= w_data_reg[b*8 +: 8];
                end
            end
        end
        mem_rd_reg <= mem[ar_idx_reg];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            last_grant_reg <= 1'b1;
            ar_full_reg    <= 1'b0;
            aw_full_reg    <= 1'b0;
            w_full_reg     <= 1'b0;
            arready_reg    <= 1'b0;
            awready_reg    <= 1'b0;
            wready_reg     <= 1'b0;
            ar_idx_reg     <= '0;
            aw_idx_reg     <= '0;
            ar_oor_reg     <= 1'b0;
            aw_oor_reg     <= 1'b0;
            w_data_reg     <= '0;
            w_strb_reg     <= '0;
            rvalid_reg     <= 1'b0;
            bvalid_reg     <= 1'b0;
            rdata_reg      <= '0;
            rresp_reg      <= 2'b00;
            bresp_reg      <= 2'b00;
        end else begin
            ar_full_reg <= ar_full_next;
            aw_full_reg <= aw_full_next;
            w_full_reg  <= w_full_next;
            arready_reg <= !ar_full_next;
            awready_reg <= !aw_full_next;
            wready_reg  <= !w_full_next;

            // Any address bit above the index field makes the access out of range.
            if (ar_cap) begin
                ar_idx_reg <= araddr[OFF_W +: IDX_W];
                ar_oor_reg <= |(araddr >> (OFF_W + IDX_W));
            end
            if (aw_cap) begin
                aw_idx_reg <= awaddr[OFF_W +: IDX_W];
                aw_oor_reg <= |(awaddr >> (OFF_W + IDX_W));
            end
            if (w_cap) begin
                w_data_reg <= wdata;
                w_strb_reg <= wstrb;
            end

            case (state_reg)
                IDLE: begin
                    if (grant_rd) begin
                        state_reg      <= RD_WAIT;
                        cnt_reg        <= 4'(LATENCY);
                        last_grant_reg <= 1'b0;
                    end else if (grant_wr) begin
                        state_reg      <= WR_WAIT;
                        cnt_reg        <= 4'(LATENCY);
                        last_grant_reg <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg  <= RD_RESP;
                        rvalid_reg <= 1'b1;
                        rdata_reg  <= ar_oor_reg ? '0 : mem_rd_reg;
                        rresp_reg  <= ar_oor_reg ? 2'b10 : 2'b00;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg  <= WR_RESP;
                        bvalid_reg <= 1'b1;
                        bresp_reg  <= aw_oor_reg ? 2'b10 : 2'b00;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign arready = arready_reg;
    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign rvalid  = rvalid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;
    assign busy    = (state_reg != IDLE);

endmodule
